// File: rtl/pif_rom_pkg.sv
// Shared types and constants for the PIF boot-ROM arbiter.
package pif_rom_pkg;

  localparam int unsigned PIF_ROM_AW     = 11;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned A_LATENCY      = 6;
  localparam int unsigned B_LATENCY      = 3;
  localparam int unsigned LOCK_LATENCY   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_ISSUE,
    ST_A_DRAIN,
    ST_A_DONE,
    ST_B_ISSUE,
    ST_B_DRAIN,
    ST_B_DONE,
    ST_A_LOCKED
  } state_e;

endpackage

// File: rtl/pif_rom_arbiter.sv
// Arbitrates the byte-wide PIF boot ROM between a 32-bit word reader (A) and a byte reader (B).
// Optional boot lockout of port A is enabled by defining PIF_ROM_LOCKOUT_EN.
module pif_rom_arbiter
  import pif_rom_pkg::*;
#(
  parameter int unsigned ADDR_W       = PIF_ROM_AW,
  parameter bit          PRIO_A_FIXED = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              a_req_i,
  input  logic [ADDR_W-3:0] a_addr_i,
  output logic              a_ack_o,
  output logic [31:0]       a_rdata_o,
  output logic              a_err_o,
  input  logic              b_req_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic              b_ack_o,
  output logic [7:0]        b_rdata_o,
  input  logic              rom_lock_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_oe_o,
  input  logic              rom_valid_i,
  input  logic [7:0]        rom_q_i
);

  localparam int unsigned CNT_W    = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_a_q, last_a_d;
  logic               lock_active_c;
  logic               grant_a_c;
  logic [31:0]        word_q, word_d;
  logic               cap_en_c;
  logic [CNT_W-1:0]   cap_lane_c;

  logic               a_ack_q, a_ack_d;
  logic [31:0]        a_rdata_q, a_rdata_d;
  logic               a_err_q, a_err_d;
  logic               b_ack_q, b_ack_d;
  logic [7:0]         b_rdata_q, b_rdata_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               rom_oe_q, rom_oe_d;

`ifdef PIF_ROM_LOCKOUT_EN
  logic lock_q, lock_d;

  // Sticky lockout; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) lock_q <= 1'b0;
    else            lock_q <= lock_d;
  end

  always_comb begin
    lock_d        = lock_q | rom_lock_i;
    lock_active_c = lock_q;
  end
`else
  logic unused_rom_lock;
  assign unused_rom_lock = rom_lock_i;
  assign lock_active_c   = 1'b0;
`endif

  // Ties: fixed A priority, or the port that did not win last time.
  assign grant_a_c = a_req_i && (!b_req_i || PRIO_A_FIXED || !last_a_q);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_a_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_a_q <= last_a_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_a_d = last_a_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_a_c) begin
          last_a_d = 1'b1;
          cnt_d    = '0;
          state_d  = lock_active_c ? ST_A_LOCKED : ST_A_ISSUE;
        end else if (b_req_i) begin
          last_a_d = 1'b0;
          state_d  = ST_B_ISSUE;
        end
      end
      ST_A_ISSUE: begin
        if (cnt_q == LAST_BYTE) state_d = ST_A_DRAIN;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_A_DRAIN:  state_d = ST_A_DONE;
      ST_A_DONE:   state_d = ST_IDLE;
      ST_B_ISSUE:  state_d = ST_B_DRAIN;
      ST_B_DRAIN:  state_d = ST_B_DONE;
      ST_B_DONE:   state_d = ST_IDLE;
      ST_A_LOCKED: state_d = ST_A_DONE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ROM returns byte n one cycle after it was issued, so the capture lane trails the issue count.
  always_comb begin
    cap_en_c   = ((state_q == ST_A_ISSUE) && (cnt_q != '0)) || (state_q == ST_A_DRAIN);
    cap_lane_c = (state_q == ST_A_DRAIN) ? cnt_q : cnt_q - CNT_W'(1);
    word_d     = word_q;
    if (cap_en_c && rom_valid_i) begin
      unique case (cap_lane_c)
        2'd0:    word_d[7:0]   = rom_q_i;
        2'd1:    word_d[15:8]  = rom_q_i;
        2'd2:    word_d[23:16] = rom_q_i;
        default: word_d[31:24] = rom_q_i;
      endcase
    end
  end

  // Output logic: values for the registered outputs in the coming cycle.
  always_comb begin
    a_ack_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    a_err_d    = a_err_q;
    b_ack_d    = 1'b0;
    b_rdata_d  = b_rdata_q;
    rom_addr_d = rom_addr_q;
    rom_oe_d   = 1'b0;

    if (state_d == ST_A_ISSUE) begin
      rom_oe_d   = 1'b1;
      rom_addr_d = {a_addr_i, cnt_d};
    end else if (state_d == ST_B_ISSUE) begin
      rom_oe_d   = 1'b1;
      rom_addr_d = b_addr_i;
    end

    unique case (state_q)
      ST_A_DRAIN: begin
        a_ack_d   = 1'b1;
        a_err_d   = 1'b0;
        a_rdata_d = word_d;
      end
      ST_A_LOCKED: begin
        a_ack_d   = 1'b1;
        a_err_d   = lock_active_c;
        a_rdata_d = '0;
      end
      ST_B_DRAIN: begin
        b_ack_d = 1'b1;
        if (rom_valid_i) b_rdata_d = rom_q_i;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      word_q     <= '0;
      a_ack_q    <= 1'b0;
      a_rdata_q  <= '0;
      a_err_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      b_rdata_q  <= '0;
      rom_addr_q <= '0;
      rom_oe_q   <= 1'b0;
    end else begin
      word_q     <= word_d;
      a_ack_q    <= a_ack_d;
      a_rdata_q  <= a_rdata_d;
      a_err_q    <= a_err_d;
      b_ack_q    <= b_ack_d;
      b_rdata_q  <= b_rdata_d;
      rom_addr_q <= rom_addr_d;
      rom_oe_q   <= rom_oe_d;
    end
  end

  assign a_ack_o    = a_ack_q;
  assign a_rdata_o  = a_rdata_q;
  assign a_err_o    = a_err_q;
  assign b_ack_o    = b_ack_q;
  assign b_rdata_o  = b_rdata_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_oe_o   = rom_oe_q;

endmodule

// File: tb/tb_pif_rom_arbiter.sv
// Directed bench for pif_rom_arbiter with a behavioural 1-cycle byte ROM behind each instance.
module tb_pif_rom_arbiter;

  logic        clk;
  logic        reset_n;
  int          n_vec;
  int          n_bad;

  // Main instance (round-robin ties).
  logic        a_req, b_req, rom_lock;
  logic [8:0]  a_addr;
  logic [10:0] b_addr;
  logic        a_ack, a_err, b_ack, rom_oe, rom_valid;
  logic [31:0] a_rdata;
  logic [7:0]  b_rdata, rom_q;
  logic [10:0] rom_addr;

  // Second instance with fixed A priority.
  logic        p_a_req, p_b_req;
  logic [8:0]  p_a_addr;
  logic [10:0] p_b_addr;
  logic        p_a_ack, p_a_err, p_b_ack, p_rom_oe, p_rom_valid;
  logic [31:0] p_a_rdata;
  logic [7:0]  p_b_rdata, p_rom_q;
  logic [10:0] p_rom_addr;
  logic        p_rom_lock;

  logic [7:0]  rom_mem [2048];

  pif_rom_arbiter #(.ADDR_W(11), .PRIO_A_FIXED(1'b0)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_ack_o(a_ack), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_ack_o(b_ack), .b_rdata_o(b_rdata),
    .rom_lock_i(rom_lock), .rom_addr_o(rom_addr), .rom_oe_o(rom_oe),
    .rom_valid_i(rom_valid), .rom_q_i(rom_q)
  );

  pif_rom_arbiter #(.ADDR_W(11), .PRIO_A_FIXED(1'b1)) dut_prio (
    .clk_i(clk), .reset_n_i(reset_n),
    .a_req_i(p_a_req), .a_addr_i(p_a_addr), .a_ack_o(p_a_ack), .a_rdata_o(p_a_rdata), .a_err_o(p_a_err),
    .b_req_i(p_b_req), .b_addr_i(p_b_addr), .b_ack_o(p_b_ack), .b_rdata_o(p_b_rdata),
    .rom_lock_i(p_rom_lock), .rom_addr_o(p_rom_addr), .rom_oe_o(p_rom_oe),
    .rom_valid_i(p_rom_valid), .rom_q_i(p_rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte ROM: data and valid one cycle after the read strobe.
  always @(posedge clk) begin
    rom_valid <= rom_oe;
    if (rom_oe) rom_q <= rom_mem[rom_addr];
    p_rom_valid <= p_rom_oe;
    if (p_rom_oe) p_rom_q <= rom_mem[p_rom_addr];
  end

  task automatic a_read(input logic [8:0] addr, output int lat, output logic [31:0] data,
                        output logic err, output logic oe_seen, output logic ack_after);
    a_addr = addr; a_req = 1'b1;
    lat = -1; data = '0; err = 1'b0; oe_seen = 1'b0; ack_after = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (rom_oe) oe_seen = 1'b1;
      if (a_ack) begin
        lat = n; data = a_rdata; err = a_err;
        break;
      end
    end
    a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    ack_after = a_ack;
  endtask

  task automatic b_read(input logic [10:0] addr, output int lat, output logic [7:0] data);
    b_addr = addr; b_req = 1'b1; lat = -1; data = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (b_ack) begin
        lat = n; data = b_rdata;
        break;
      end
    end
    b_req = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({a_ack, a_err, b_ack, rom_oe} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {a_ack, a_err, b_ack, rom_oe}); end
    n_vec++; if (a_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_a_rdata: got %h want 00000000", a_rdata); end
    n_vec++; if ({b_rdata, rom_addr} !== 19'h0) begin
      n_bad++; $display("FAIL reset_b_rdata_rom_addr: got %h/%h want 00/000", b_rdata, rom_addr); end
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_tie_round_robin();
    int order [2];
    int k;
    logic [7:0] bdat;
    k = 0; bdat = '0;
    a_addr = 9'd1; b_addr = 11'h003;
    a_req = 1'b1; b_req = 1'b1;
    for (int n = 1; n <= 40 && k < 2; n++) begin
      @(posedge clk); @(negedge clk);
      if (a_ack) begin order[k] = 1; k++; end
      else if (b_ack) begin order[k] = 2; bdat = b_rdata; k++; end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (k !== 2) begin
      n_bad++; $display("FAIL tie_rr_acks: got %0d acks want 2", k); end
    n_vec++; if (order[0] !== 1) begin
      n_bad++; $display("FAIL tie_rr_first: got port %0d want 1 (A)", order[0]); end
    n_vec++; if (order[1] !== 2) begin
      n_bad++; $display("FAIL tie_rr_second: got port %0d want 2 (B)", order[1]); end
    n_vec++; if (bdat !== 8'h3C) begin
      n_bad++; $display("FAIL tie_rr_b_data: got %h want 3c", bdat); end
  endtask

  task automatic test_tie_fixed_prio();
    int order [2];
    int k;
    k = 0;
    p_a_addr = 9'd0; p_b_addr = 11'h003;
    p_a_req = 1'b1; p_b_req = 1'b1;
    for (int n = 1; n <= 40 && k < 2; n++) begin
      @(posedge clk); @(negedge clk);
      if (p_a_ack) begin order[k] = 1; k++; end
      else if (p_b_ack) begin order[k] = 2; k++; end
    end
    p_a_req = 1'b0; p_b_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if (k !== 2 || order[0] !== 1 || order[1] !== 1) begin
      n_bad++; $display("FAIL tie_fixed_order: got %0d acks %0d,%0d want 2 acks 1,1", k, order[0], order[1]); end
    n_vec++; if (p_a_rdata !== 32'h3C093400) begin
      n_bad++; $display("FAIL tie_fixed_data: got %h want 3c093400", p_a_rdata); end
  endtask

  task automatic test_a_read();
    int lat; logic [31:0] d; logic e, oe, aa;
    a_read(9'd0, lat, d, e, oe, aa);
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL a0_latency: got %0d want 6", lat); end
    n_vec++; if (d !== 32'h3C093400) begin n_bad++; $display("FAIL a0_data: got %h want 3c093400", d); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL a0_err: got %b want 0", e); end
    n_vec++; if (aa !== 1'b0) begin n_bad++; $display("FAIL a0_ack_width: got %b want 0", aa); end
    a_read(9'd1, lat, d, e, oe, aa);
    n_vec++; if (lat !== 6 || d !== 32'h40896000) begin
      n_bad++; $display("FAIL a1_read: got lat %0d data %h want 6 40896000", lat, d); end
    n_vec++; if (a_rdata !== 32'h40896000) begin
      n_bad++; $display("FAIL a1_hold: got %h want 40896000", a_rdata); end
  endtask

  task automatic test_b_read();
    logic [10:0] addrs [3];
    logic [7:0]  exp   [3];
    int lat; logic [7:0] d;
    addrs[0] = 11'h7FF; exp[0] = 8'hFF;
    addrs[1] = 11'h7F8; exp[1] = 8'h00;
    addrs[2] = 11'h003; exp[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      b_read(addrs[i], lat, d);
      n_vec++; if (lat !== 3) begin
        n_bad++; $display("FAIL b_latency[%0d]: got %0d want 3", i, lat); end
      n_vec++; if (d !== exp[i]) begin
        n_bad++; $display("FAIL b_data[%0d]: got %h want %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic seen_ack;
    int lat; logic [31:0] d; logic e, oe, aa;
    seen_ack = 1'b0;
    a_addr = 9'd1; a_req = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    reset_n = 1'b0; a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    n_vec++; if ({a_ack, a_err, b_ack, rom_oe} !== 4'b0000 || a_rdata !== 32'h0 || rom_addr !== 11'h0) begin
      n_bad++; $display("FAIL midop_reset_outputs: got flags %b rdata %h addr %h want 0",
                        {a_ack, a_err, b_ack, rom_oe}, a_rdata, rom_addr); end
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      if (a_ack) seen_ack = 1'b1;
    end
    n_vec++; if (seen_ack !== 1'b0) begin
      n_bad++; $display("FAIL midop_no_ack: got %b want 0", seen_ack); end
    a_read(9'd0, lat, d, e, oe, aa);
    n_vec++; if (lat !== 6 || d !== 32'h3C093400) begin
      n_bad++; $display("FAIL midop_fresh_read: got lat %0d data %h want 6 3c093400", lat, d); end
  endtask

  task automatic test_back_to_back();
    int ack_n [2];
    int k;
    logic gap_oe, gap_ack, after_ack;
    k = 0; gap_oe = 1'b1; gap_ack = 1'b1;
    ack_n[0] = -1; ack_n[1] = -1;
    a_addr = 9'd0; a_req = 1'b1;
    for (int n = 1; n <= 30 && k < 2; n++) begin
      @(posedge clk); @(negedge clk);
      if (a_ack) begin ack_n[k] = n; k++; end
      if (n == 7) begin gap_oe = rom_oe; gap_ack = a_ack; end
    end
    a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    after_ack = a_ack;
    n_vec++; if (ack_n[0] !== 6 || ack_n[1] !== 13) begin
      n_bad++; $display("FAIL b2b_ack_cycles: got %0d,%0d want 6,13", ack_n[0], ack_n[1]); end
    n_vec++; if (gap_oe !== 1'b0 || gap_ack !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle_gap: got oe %b ack %b want 0 0", gap_oe, gap_ack); end
    n_vec++; if (after_ack !== 1'b0 || a_rdata !== 32'h3C093400) begin
      n_bad++; $display("FAIL b2b_end: got ack %b data %h want 0 3c093400", after_ack, a_rdata); end
  endtask

  task automatic test_lockout();
    int lat; logic [31:0] d; logic e, oe, aa;
    int blat; logic [7:0] bd;
    rom_lock = 1'b1;
    @(posedge clk); @(negedge clk);
    rom_lock = 1'b0;
    a_read(9'd0, lat, d, e, oe, aa);
`ifdef PIF_ROM_LOCKOUT_EN
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL lock_latency: got %0d want 2", lat); end
    n_vec++; if (d !== 32'h0 || e !== 1'b1) begin
      n_bad++; $display("FAIL lock_resp: got data %h err %b want 00000000 1", d, e); end
    n_vec++; if (oe !== 1'b0) begin n_bad++; $display("FAIL lock_rom_oe: got %b want 0", oe); end
`else
    n_vec++; if (lat !== 6) begin n_bad++; $display("FAIL nolock_latency: got %0d want 6", lat); end
    n_vec++; if (d !== 32'h3C093400 || e !== 1'b0) begin
      n_bad++; $display("FAIL nolock_resp: got data %h err %b want 3c093400 0", d, e); end
    n_vec++; if (oe !== 1'b1) begin n_bad++; $display("FAIL nolock_rom_oe: got %b want 1", oe); end
`endif
    b_read(11'h003, blat, bd);
    n_vec++; if (blat !== 3 || bd !== 8'h3C) begin
      n_bad++; $display("FAIL lock_b_read: got lat %0d data %h want 3 3c", blat, bd); end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    rom_mem[0] = 8'h00; rom_mem[1] = 8'h34; rom_mem[2] = 8'h09; rom_mem[3] = 8'h3C;
    rom_mem[4] = 8'h00; rom_mem[5] = 8'h60; rom_mem[6] = 8'h89; rom_mem[7] = 8'h40;
    rom_mem[11'h7F8] = 8'h00; rom_mem[11'h7FF] = 8'hFF;
    reset_n = 1'b0; rom_lock = 1'b0; p_rom_lock = 1'b0;
    a_req = 1'b0; b_req = 1'b0; a_addr = '0; b_addr = '0;
    p_a_req = 1'b0; p_b_req = 1'b0; p_a_addr = '0; p_b_addr = '0;
    rom_valid = 1'b0; rom_q = '0; p_rom_valid = 1'b0; p_rom_q = '0;
    @(negedge clk);

    test_reset();
    test_tie_round_robin();
    test_tie_fixed_prio();
    test_a_read();
    test_b_read();
    test_reset_mid_op();
    test_back_to_back();
    test_lockout();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
